latch_bank_wr_ctrl: RTL and testbench

LATCH_BANK_WR_CTRL -- requirements
Module: latch_bank_wr_ctrl

---
 rtl/latch_bank_pkg.sv | 23 ++
 rtl/latch_bank_wr_ctrl_rr_arb2.sv | 41 ++++
 rtl/latch_bank_wr_ctrl.sv | 115 +++++++++++
 tb/tb_latch_bank_wr_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_bank_pkg.sv
// Shared types for the latch-bank write controller: FSM states, default widths, requester id.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package latch_bank_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  // One state per cycle: data setup, gate open, data hold.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } wr_state_t;

  // Identifies requester 0 or 1.
  typedef logic req_id_t;

  // Pointer starts at requester 1 so requester 0 wins the first tie.
  localparam req_id_t RR_PTR_RST = 1'b1;

endpackage

// File: rtl/latch_bank_wr_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the winner of a tie is the requester not granted last.
// Latency: grant is combinational in the cycle the requests are seen; pointer moves on the grant edge.
// Backpressure: grants only while en is high; an ungranted requester keeps its request up.
// Ports: clk/rst, req0/req1 requests, en arbitration window, gnt0/gnt1 one-hot grant, gnt_id winner.
module rr_arb2
  import latch_bank_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req0,
  input  logic    req1,
  input  logic    en,
  output logic    gnt0,
  output logic    gnt1,
  output req_id_t gnt_id
);

  req_id_t last_q;
  logic    any_req;

  assign any_req = req0 | req1;

  always_comb begin
    gnt_id = 1'b0;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if (en && any_req) begin
      // Lone requester wins outright; on a tie the one not served last wins.
      if (req0 && req1) gnt_id = ~last_q;
      else              gnt_id = req1;
      gnt0 = (gnt_id == 1'b0);
      gnt1 = (gnt_id == 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              last_q <= RR_PTR_RST;
    else if (gnt0 | gnt1) last_q <= gnt_id;
  end

endmodule

// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer for a latch bank: SETUP (data on bus), OPEN (one gate high), HOLD (gate closed).
// Latency: accept at t, WDATA valid t+1, LE pulse at t+2, next accept no earlier than t+4.
// Backpressure: READY only in IDLE; requesters hold VALID while BUSY, nothing is queued inside.
// Ports: CLK/RST; REQx_VALID/ADDR/DATA in, REQx_READY out; WDATA to latch D pins,
//        LE one-hot registered gate enables, BUSY while a sequence runs, GNT_ID current owner.
module latch_bank_wr_ctrl
  import latch_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ0_VALID,
  input  logic                 REQ1_VALID,
  input  logic [ADDR_W-1:0]    REQ0_ADDR,
  input  logic [ADDR_W-1:0]    REQ1_ADDR,
  input  logic [DATA_W-1:0]    REQ0_DATA,
  input  logic [DATA_W-1:0]    REQ1_DATA,
  output logic                 REQ0_READY,
  output logic                 REQ1_READY,
  output logic [DATA_W-1:0]    WDATA,
  output logic [2**ADDR_W-1:0] LE,
  output logic                 BUSY,
  output logic                 GNT_ID
);

  localparam int N_ENT = 2**ADDR_W;

  wr_state_t         state_q;
  wr_state_t         state_d;
  logic              arb_en;
  logic              gnt0;
  logic              gnt1;
  logic              accept;
  req_id_t           win_id;
  req_id_t           id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [N_ENT-1:0]  le_q;
  logic [N_ENT-1:0]  le_d;

  assign arb_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk    (CLK),
    .rst    (RST),
    .req0   (REQ0_VALID),
    .req1   (REQ1_VALID),
    .en     (arb_en),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .gnt_id (win_id)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = OPEN;
      OPEN:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    REQ0_READY = gnt0;
    REQ1_READY = gnt1;
    accept     = gnt0 | gnt1;
    BUSY       = (state_q != IDLE);
    // Decode for the gate flop: only the cycle spent in OPEN sees a bit set.
    le_d = '0;
    if (state_d == OPEN) le_d[addr_q] = 1'b1;
  end

  // Captured request; data_q doubles as the WDATA driver, so the bus only
  // moves on the IDLE->SETUP edge and otherwise shows the last written word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q <= '0;
      data_q <= '0;
      id_q   <= 1'b0;
    end else if (accept) begin
      id_q <= win_id;
      if (win_id) begin
        addr_q <= REQ1_ADDR;
        data_q <= REQ1_DATA;
      end else begin
        addr_q <= REQ0_ADDR;
        data_q <= REQ0_DATA;
      end
    end
  end

  // Gate enables come straight from a flop so the latch clock pins never
  // see decode glitches; async reset closes an open gate immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) le_q <= '0;
    else     le_q <= le_d;
  end

  assign LE     = le_q;
  assign WDATA  = data_q;
  assign GNT_ID = id_q;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Self-checking bench: per-cycle reference model plus directed literal scenarios and random traffic.
// Latency: n/a.
// Backpressure: requesters hold VALID until their READY is seen.
module tb_latch_bank_wr_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NE = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          REQ0_VALID = 1'b0;
  logic          REQ1_VALID = 1'b0;
  logic [AW-1:0] REQ0_ADDR = '0;
  logic [AW-1:0] REQ1_ADDR = '0;
  logic [DW-1:0] REQ0_DATA = '0;
  logic [DW-1:0] REQ1_DATA = '0;
  logic          REQ0_READY;
  logic          REQ1_READY;
  logic [DW-1:0] WDATA;
  logic [NE-1:0] LE;
  logic          BUSY;
  logic          GNT_ID;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  latch_bank_wr_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ0_VALID (REQ0_VALID),
    .REQ1_VALID (REQ1_VALID),
    .REQ0_ADDR  (REQ0_ADDR),
    .REQ1_ADDR  (REQ1_ADDR),
    .REQ0_DATA  (REQ0_DATA),
    .REQ1_DATA  (REQ1_DATA),
    .REQ0_READY (REQ0_READY),
    .REQ1_READY (REQ1_READY),
    .WDATA      (WDATA),
    .LE         (LE),
    .BUSY       (BUSY),
    .GNT_ID     (GNT_ID)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a write is a timeline relative to its accept edge.
  // phase 0 = free, phase k = k cycles after the accept edge (k=1..3).
  int            m_phase;
  logic [DW-1:0] m_wdata;
  logic [AW-1:0] m_addr;
  logic          m_gnt;
  logic          m_last;
  int            win;
  logic [NE-1:0] exp_le;

  // Observed gate pulses and grants, for the directed scenarios.
  int pulse_le[$];
  int pulse_wd[$];
  int pulse_cyc[$];
  int grant_q[$];

  always @(negedge CLK) begin
    if (RST) begin
      m_phase = 0;
      m_wdata = '0;
      m_addr  = '0;
      m_gnt   = 1'b0;
      m_last  = 1'b1;
    end else begin
      win = -1;
      if (m_phase == 0) begin
        if (REQ0_VALID && REQ1_VALID) win = m_last ? 0 : 1;
        else if (REQ0_VALID)          win = 0;
        else if (REQ1_VALID)          win = 1;
      end
      exp_le = '0;
      if (m_phase == 2) exp_le = NE'(1) << m_addr;

      chk("ready0", REQ0_READY, (win == 0));
      chk("ready1", REQ1_READY, (win == 1));
      chk("busy", BUSY, (m_phase != 0));
      chk("le", LE, exp_le);
      chk("wdata", WDATA, m_wdata);
      chk("gnt_id", GNT_ID, m_gnt);
      chk("le_onehot0", $onehot0(LE), 1);
      chk("ready_excl", (REQ0_READY & REQ1_READY), 0);

      if (LE != 0) begin
        pulse_le.push_back(int'(LE));
        pulse_wd.push_back(int'(WDATA));
        pulse_cyc.push_back(cyc);
      end
      if (REQ0_READY) grant_q.push_back(0);
      if (REQ1_READY) grant_q.push_back(1);

      if (win >= 0) begin
        m_phase = 1;
        m_last  = (win == 1);
        m_gnt   = (win == 1);
        m_addr  = (win == 1) ? REQ1_ADDR : REQ0_ADDR;
        m_wdata = (win == 1) ? REQ1_DATA : REQ0_DATA;
      end else if (m_phase != 0) begin
        m_phase = (m_phase + 1) % 4;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    repeat (2) tick();
    RST = 1'b0;
  endtask

  task automatic clear_obs();
    pulse_le.delete();
    pulse_wd.delete();
    pulse_cyc.delete();
    grant_q.delete();
  endtask

  task automatic check_pulse(input string name, input int idx, input int le, input int wd);
    chk({name, "_exists"}, (pulse_le.size() > idx), 1);
    if (pulse_le.size() > idx) begin
      chk({name, "_le"}, pulse_le[idx], le);
      chk({name, "_wd"}, pulse_wd[idx], wd);
    end
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n;
    logic a0, a1;

    // Reset values while RST is held
    #2;
    chk("rst_le", LE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_wdata", WDATA, 0);
    chk("rst_gnt", GNT_ID, 0);
    chk("rst_ready0", REQ0_READY, 0);
    tick();
    tick();
    RST = 1'b0;

    // Single write: addr 3, data A5
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd3; REQ0_DATA = 8'hA5;
    @(negedge CLK);
    chk("t1_ready0_c0", REQ0_READY, 1);
    chk("t1_busy_c0", BUSY, 0);
    tick();
    REQ0_VALID = 1'b0;
    @(negedge CLK);
    chk("t1_wdata_c1", WDATA, 8'hA5);
    chk("t1_busy_c1", BUSY, 1);
    chk("t1_le_c1", LE, 0);
    tick();
    @(negedge CLK);
    chk("t1_le_c2", LE, 8'h08);
    chk("t1_busy_c2", BUSY, 1);
    tick();
    @(negedge CLK);
    chk("t1_le_c3", LE, 0);
    chk("t1_busy_c3", BUSY, 1);
    chk("t1_wdata_c3", WDATA, 8'hA5);
    tick();
    @(negedge CLK);
    chk("t1_busy_c4", BUSY, 0);
    chk("t1_wdata_c4", WDATA, 8'hA5);

    // Both requesters valid continuously from reset: grants alternate 0,1,0,1
    tick();
    do_reset();
    clear_obs();
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd0; REQ0_DATA = 8'h11;
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd7; REQ1_DATA = 8'h22;
    repeat (16) tick();
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    repeat (4) tick();
    chk("t2_grant_count", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      chk("t2_grant_order", grant_q[i], i % 2);
    chk("t2_pulse_count", pulse_le.size(), 4);
    for (int i = 0; i < 4; i++)
      check_pulse("t2_pulse", i, (i % 2) ? 8'h80 : 8'h01, (i % 2) ? 8'h22 : 8'h11);
    for (int i = 1; i < 4 && i < pulse_cyc.size(); i++)
      chk("t2_pulse_spacing", pulse_cyc[i] - pulse_cyc[i-1], 4);

    // Requester 1 arrives while busy: waits until the sequence ends
    clear_obs();
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd1; REQ0_DATA = 8'h33;
    @(negedge CLK);
    chk("t3_ready0", REQ0_READY, 1);
    tick();
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd6; REQ1_DATA = 8'h44;
    n = 0;
    @(negedge CLK);
    while (!REQ1_READY && n < 10) begin
      n++;
      @(negedge CLK);
    end
    chk("t3_wait_cycles", n, 3);
    tick();
    REQ1_VALID = 1'b0;
    repeat (4) tick();
    chk("t3_pulse_count", pulse_le.size(), 2);
    check_pulse("t3_pulse", 0, 8'h02, 8'h33);
    check_pulse("t3_pulse", 1, 8'h40, 8'h44);
    if (pulse_cyc.size() == 2) chk("t3_pulse_spacing", pulse_cyc[1] - pulse_cyc[0], 4);

    // Reset in the middle of OPEN closes the gate at once and abandons the write
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd4; REQ0_DATA = 8'h5A;
    @(negedge CLK);
    tick();
    REQ0_VALID = 1'b0;
    tick();
    chk("t4_le_open", LE, 8'h10);
    #2;
    RST = 1'b1;
    #1;
    chk("t4_le_async", LE, 0);
    chk("t4_busy_async", BUSY, 0);
    chk("t4_wdata_async", WDATA, 0);
    chk("t4_gnt_async", GNT_ID, 0);
    tick();
    RST = 1'b0;
    clear_obs();
    REQ1_VALID = 1'b1; REQ1_ADDR = 3'd2; REQ1_DATA = 8'h77;
    @(negedge CLK);
    chk("t4_ready1_after", REQ1_READY, 1);
    tick();
    REQ1_VALID = 1'b0;
    repeat (5) tick();
    chk("t4_pulse_count", pulse_le.size(), 1);
    check_pulse("t4_pulse", 0, 8'h04, 8'h77);

    // Same address back to back: two full sequences
    clear_obs();
    REQ0_VALID = 1'b1; REQ0_ADDR = 3'd5; REQ0_DATA = 8'h01;
    @(negedge CLK);
    tick();
    REQ0_DATA = 8'h02;
    n = 0;
    @(negedge CLK);
    while (!REQ0_READY && n < 10) begin
      n++;
      @(negedge CLK);
    end
    chk("t5_wait_cycles", n, 3);
    tick();
    REQ0_VALID = 1'b0;
    repeat (5) tick();
    chk("t5_pulse_count", pulse_le.size(), 2);
    check_pulse("t5_pulse", 0, 8'h20, 8'h01);
    check_pulse("t5_pulse", 1, 8'h20, 8'h02);
    if (pulse_cyc.size() == 2) chk("t5_pulse_spacing", pulse_cyc[1] - pulse_cyc[0], 4);

    // Random traffic; each requester holds its request until granted
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      a0 = REQ0_READY;
      a1 = REQ1_READY;
      @(posedge CLK);
      #1;
      if ($urandom_range(0, 149) == 0) begin
        RST = 1'b1;
        tick();
        RST = 1'b0;
        continue;
      end
      if (!REQ0_VALID || a0) begin
        REQ0_VALID = ($urandom_range(0, 2) != 0);
        REQ0_ADDR  = AW'($urandom_range(0, NE - 1));
        REQ0_DATA  = DW'($urandom);
      end
      if (!REQ1_VALID || a1) begin
        REQ1_VALID = ($urandom_range(0, 2) != 0);
        REQ1_ADDR  = AW'($urandom_range(0, NE - 1));
        REQ1_DATA  = DW'($urandom);
      end
    end
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
